// File: rtl/uart_rx_packer_if.sv
// Packed-word stream leaving the UART packer: valid/ready handshake carrying WORD_BYTES bytes.
interface uart_rx_packer_if #(
   parameter int WORD_BYTES = 4
);
   logic                    word_valid;
   logic                    word_ready;
   logic [8*WORD_BYTES-1:0] word_data;

   modport master (output word_valid, output word_data, input word_ready);
   modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/uart_rx_packer.sv
// UART receiver feeding a byte FIFO; the packer pops WORD_BYTES bytes at a time into a
// handshaked word until word_number words have been delivered for the current transfer.
module uart_rx_packer #(
   parameter int CLK_DIV    = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 16,
   parameter int WORD_BYTES = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             rx,
   input  logic             start,
   input  logic [7:0]       word_number,
   uart_rx_packer_if.master ws,
   output logic             done,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err,
   output logic             overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIV - 1);
   localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic [PW-1:0] WB_CNT   = PW'(WORD_BYTES);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [3:0]              bit_cnt;
   logic                    par_bad;
   logic                    live;
   logic [DATA_BITS-1:0]    sh;
   logic                    rx_p0, rx_p1, rx_p2;
   logic [7:0]              mem [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr, rd_ptr, count;
   logic                    full, empty;
   logic [7:0]              delivered, word_num_q;
   logic [8*WORD_BYTES-1:0] packed_word;
   logic                    start_ok, bit_tick, push_req, do_pop;

   function automatic logic exp_parity(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

   // Stage p0/p1: two-flop synchronizer; p2 is only the previous value for edge detection
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   assign start_ok = start && !busy;
   assign bit_tick = (cnt == '0);
   assign push_req = (state == S_STOP) && bit_tick && rx_p1 && !par_bad && live && busy;

   // live marks a character that belongs to the current transfer; stale ones finish silently
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         par_bad    <= 1'b0;
         live       <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (start_ok) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            live       <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (busy && rx_p2 && !rx_p1) begin
                  state <= S_START;
                  cnt   <= HALF_M1;
                  live  <= 1'b1;
               end
            end
            S_START: begin
               if (!bit_tick) cnt <= cnt - 1'b1;
               else if (!rx_p1) begin
                  state   <= S_DATA;
                  cnt     <= FULL_M1;
                  bit_cnt <= '0;
                  par_bad <= 1'b0;
               end else state <= S_IDLE;
            end
            S_DATA: begin
               if (!bit_tick) cnt <= cnt - 1'b1;
               else begin
                  cnt <= FULL_M1;
                  if (bit_cnt == LAST_BIT) state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  else bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (!bit_tick) cnt <= cnt - 1'b1;
               else begin
                  cnt   <= FULL_M1;
                  state <= S_STOP;
                  if (rx_p1 != exp_parity(sh)) begin
                     par_bad <= 1'b1;
                     if (busy && live) parity_err <= 1'b1;
                  end
               end
            end
            S_STOP: begin
               if (!bit_tick) cnt <= cnt - 1'b1;
               else begin
                  state <= S_IDLE;
                  if (!rx_p1 && busy && live) frame_err <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_DATA && bit_tick) sh <= {rx_p1, sh[DATA_BITS-1:1]};
   end

   assign count = wr_ptr - rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign do_pop = busy && !ws.word_valid && !empty && (count >= WB_CNT) &&
                   (delivered < word_num_q);

   always_ff @(posedge clk) begin
      if (push_req && !full) mem[wr_ptr[AW-1:0]] <= 8'(sh);
   end

   always_comb begin
      packed_word = '0;
      for (int i = 0; i < WORD_BYTES; i++)
         packed_word[8*i +: 8] = mem[rd_ptr[AW-1:0] + AW'(i)];
   end

   // Push, pop and handshake are independent so a same-cycle push and pop both land
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         delivered     <= '0;
         word_num_q    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         ws.word_valid <= 1'b0;
         ws.word_data  <= '0;
      end else begin
         done <= 1'b0;
         if (start_ok) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            delivered     <= '0;
            overflow      <= 1'b0;
            word_num_q    <= word_number;
            busy          <= 1'b1;
            ws.word_valid <= 1'b0;
         end else begin
            if (push_req) begin
               if (!full) wr_ptr <= wr_ptr + 1'b1;
               else overflow <= 1'b1;
            end
            if (do_pop) begin
               rd_ptr        <= rd_ptr + WB_CNT;
               ws.word_data  <= packed_word;
               ws.word_valid <= 1'b1;
            end
            if (ws.word_valid && ws.word_ready) begin
               ws.word_valid <= 1'b0;
               delivered     <= delivered + 8'd1;
               if ((delivered + 8'd1) == word_num_q) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            if (busy && word_num_q == 8'd0) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed-plus-random bench: three packer instances (default, even parity, 4-deep FIFO)
// driven serially and compared against a byte-queue model of the accepted characters.
module tb_uart_rx_packer;
   localparam int CLK_DIV = 16;

   logic             clk = 1'b0;
   logic             resetn;
   logic [2:0]       rx, start, rdy;
   logic [2:0][7:0]  wnum;
   logic [2:0]       wv, done_o, busy_o, fe, pe, ov;
   logic [2:0][31:0] wd;
   int               n_err = 0;
   int               n_chk = 0;
   logic [7:0]       mq [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      uart_rx_packer_if #(.WORD_BYTES(4)) ws ();
      assign ws.word_ready = rdy[g];
      assign wv[g] = ws.word_valid;
      assign wd[g] = ws.word_data;
      uart_rx_packer #(
         .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(g == 1 ? 1 : 0), .PARITY_ODD(0),
         .FIFO_DEPTH(g == 2 ? 4 : 16), .WORD_BYTES(4)
      ) dut (
         .clk(clk), .resetn(resetn), .rx(rx[g]), .start(start[g]), .word_number(wnum[g]),
         .ws(ws.master), .done(done_o[g]), .busy(busy_o[g]), .frame_err(fe[g]),
         .parity_err(pe[g]), .overflow(ov[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input int d, input logic v);
      rx[d] = v;
      repeat (CLK_DIV) tick();
   endtask

   // pbit < 0 means no parity bit on the line
   task automatic send_char(input int d, input logic [7:0] b, input int pbit, input logic stop);
      hold(d, 1'b0);
      for (int i = 0; i < 8; i++) hold(d, b[i]);
      if (pbit >= 0) hold(d, pbit[0]);
      hold(d, stop);
      rx[d] = 1'b1;
      repeat (4) tick();
   endtask

   task automatic do_start(input int d, input logic [7:0] n);
      start[d] = 1'b1;
      wnum[d]  = n;
      tick();
      start[d] = 1'b0;
   endtask

   task automatic wait_valid(input int d, input string tag);
      for (int i = 0; i < 200 && !wv[d]; i++) tick();
      check({tag, "_valid"}, 32'(wv[d]), 32'd1);
   endtask

   task automatic take_word(input int d, input string tag, input logic [31:0] exp, input bit last);
      wait_valid(d, tag);
      check({tag, "_data"}, wd[d], exp);
      rdy[d] = 1'b1;
      tick();
      rdy[d] = 1'b0;
      check({tag, "_vld_drop"}, 32'(wv[d]), 32'd0);
      check({tag, "_done_busy"}, {30'd0, done_o[d], busy_o[d]}, last ? 32'd2 : 32'd1);
      if (last) begin
         tick();
         check({tag, "_done_pulse"}, 32'(done_o[d]), 32'd0);
      end
   endtask

   task automatic take_model_word(input int d, input string tag, input bit last);
      logic [31:0] e;
      e = {mq[3], mq[2], mq[1], mq[0]};
      repeat (4) void'(mq.pop_front());
      take_word(d, tag, e, last);
   endtask

   task automatic check_idle(input int d, input string tag);
      check({tag, "_data"}, wd[d], 32'd0);
      check({tag, "_ctl"}, {26'd0, wv[d], done_o[d], busy_o[d], fe[d], pe[d], ov[d]}, 32'd0);
   endtask

   task automatic send_good(input int d, input int n, input bit par);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         mq.push_back(b);
         send_char(d, b, par ? ($countones(b) % 2) : -1, 1'b1);
      end
   endtask

   initial begin
      logic [31:0] cap;
      logic [7:0]  b;
      int          unstable;
      bit          exp_err, bad;
      int          pb;

      resetn = 1'b0;
      rx = '1; start = '0; rdy = '0; wnum = '0;
      #22;
      for (int d = 0; d < 3; d++) check_idle(d, $sformatf("reset%0d", d));
      repeat (3) tick();
      resetn = 1'b1;
      tick();

      // Line activity while idle is ignored
      send_char(0, 8'h99, -1, 1'b1);
      check("idle_ignore", {30'd0, busy_o[0], wv[0]}, 32'd0);

      // Basic transfer with backpressure
      do_start(0, 8'd2);
      check("basic_busy", {30'd0, busy_o[0], done_o[0]}, 32'd2);
      for (int i = 1; i <= 8; i++) send_char(0, 8'(8'h11 * i), -1, 1'b1);
      wait_valid(0, "bp");
      cap = wd[0];
      unstable = 0;
      repeat (50) begin
         tick();
         if (wd[0] !== cap || wv[0] !== 1'b1) unstable++;
      end
      check("bp_stable", 32'(unstable), 32'd0);
      check("bp_overflow", 32'(ov[0]), 32'd0);
      take_word(0, "basic_w0", 32'h44332211, 1'b0);
      do_start(0, 8'd0);
      check("start_busy_ignored", 32'(busy_o[0]), 32'd1);
      take_word(0, "basic_w1", 32'h88776655, 1'b1);
      check("basic_flags", {29'd0, fe[0], pe[0], ov[0]}, 32'd0);

      // Zero-word transfer
      do_start(0, 8'd0);
      check("zero_busy", {30'd0, busy_o[0], done_o[0]}, 32'd2);
      tick();
      check("zero_done", {30'd0, busy_o[0], done_o[0]}, 32'd1);
      tick();
      check("zero_end", {30'd0, busy_o[0], done_o[0]}, 32'd0);

      // Framing error then four good bytes
      do_start(0, 8'd1);
      send_char(0, 8'hA5, -1, 1'b0);
      check("frame_err_set", 32'(fe[0]), 32'd1);
      mq.delete();
      send_good(0, 4, 1'b0);
      take_model_word(0, "frame_w", 1'b1);
      check("frame_err_sticky", 32'(fe[0]), 32'd1);

      // Random bytes with random stop-bit errors
      do_start(0, 8'd3);
      check("start_clears_fe", 32'(fe[0]), 32'd0);
      mq.delete();
      exp_err = 1'b0;
      while (mq.size() < 12) begin
         b = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         if (bad) exp_err = 1'b1;
         else mq.push_back(b);
         send_char(0, b, -1, !bad);
      end
      for (int w = 0; w < 3; w++) take_model_word(0, $sformatf("rand_w%0d", w), w == 2);
      check("rand_fe", 32'(fe[0]), 32'(exp_err));

      // Directed parity case on the even-parity instance
      do_start(1, 8'd1);
      send_char(1, 8'h03, 1, 1'b1);
      check("parity_err_set", 32'(pe[1]), 32'd1);
      mq.delete();
      mq.push_back(8'h03);
      send_char(1, 8'h03, 0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         mq.push_back(b);
         send_char(1, b, $countones(b) % 2, 1'b1);
      end
      take_model_word(1, "parity_w", 1'b1);

      // Random parity good/bad
      do_start(1, 8'd2);
      check("start_clears_pe", 32'(pe[1]), 32'd0);
      mq.delete();
      exp_err = 1'b0;
      while (mq.size() < 8) begin
         b = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         pb = ($countones(b) % 2) ^ int'(bad);
         if (bad) exp_err = 1'b1;
         else mq.push_back(b);
         send_char(1, b, pb, 1'b1);
      end
      for (int w = 0; w < 2; w++) take_model_word(1, $sformatf("prand_w%0d", w), w == 1);
      check("prand_pe", 32'(pe[1]), 32'(exp_err));

      // Overflow on the 4-deep FIFO instance: ninth byte is dropped
      do_start(2, 8'd2);
      mq.delete();
      send_good(2, 9, 1'b0);
      check("overflow_set", 32'(ov[2]), 32'd1);
      take_model_word(2, "ovf_w0", 1'b0);
      take_model_word(2, "ovf_w1", 1'b1);

      // Short glitch yields no byte and no error
      do_start(0, 8'd1);
      rx[0] = 1'b0;
      repeat (3) tick();
      rx[0] = 1'b1;
      repeat (30) tick();
      check("glitch_quiet", {29'd0, wv[0], fe[0], pe[0]}, 32'd0);
      mq.delete();
      send_good(0, 4, 1'b0);
      take_model_word(0, "glitch_w", 1'b1);

      // Reset in the middle of the data bits
      do_start(0, 8'd1);
      hold(0, 1'b0);
      hold(0, 1'b1);
      hold(0, 1'b0);
      hold(0, 1'b1);
      resetn = 1'b0;
      #2;
      check_idle(0, "midreset");
      rx[0] = 1'b1;
      repeat (5) tick();
      resetn = 1'b1;
      tick();
      send_char(0, 8'h5A, -1, 1'b1);
      check("post_reset_wait", {30'd0, busy_o[0], wv[0]}, 32'd0);
      do_start(0, 8'd1);
      mq.delete();
      send_good(0, 4, 1'b0);
      take_model_word(0, "post_reset_w", 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_rx_packer.md
UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 Parameter CLK_DIV, default 16, clock cycles per UART bit; even, at least 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per character; legal 5..8.
REQ-003 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.
REQ-005 Parameter FIFO_DEPTH, default 16, byte FIFO depth; power of 2, at least WORD_BYTES.
REQ-006 Parameter WORD_BYTES, default 4, bytes packed per output word.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 rx  in  1  serial line, idle high; asynchronous to clk.
REQ-010 start  in  1  one-cycle pulse that arms a transfer and latches word_number.
REQ-011 word_number  in  8  number of words to deliver in this transfer.
REQ-012 word_valid  out  1  word_data holds a packed word.
REQ-013 word_ready  in  1  consumer accepts word_data.
REQ-014 word_data  out  8*WORD_BYTES  packed word; first-received byte in bits [7:0].
REQ-015 done  out  1  one-cycle pulse when the transfer completes.
REQ-016 busy  out  1  high from start until done.
REQ-017 frame_err, parity_err, overflow  out  1 each  sticky error flags.

Function
REQ-018 rx SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-019 The receiver FSM SHALL use states IDLE, START, DATA, PARITY and STOP.
REQ-020 The receiver SHALL leave IDLE on a synchronized high-to-low transition only while busy = 1; rx activity while not busy SHALL be ignored.
REQ-021 START SHALL resample rx after CLK_DIV/2 cycles: 0 -> DATA; 1 -> IDLE (glitch), with no byte and no error.
REQ-022 DATA SHALL sample DATA_BITS bits, LSB first, each exactly CLK_DIV cycles after the previous sample; then go to PARITY if PARITY_EN = 1, else to STOP.
REQ-023 PARITY SHALL compare the sampled bit with the expected parity (XOR of data bits, inverted when PARITY_ODD = 1); on mismatch, parity_err SHALL set and the byte SHALL be discarded.
REQ-024 STOP SHALL sample rx CLK_DIV cycles after the last sample: 0 -> frame_err set and byte discarded; 1 -> byte accepted. STOP SHALL always return to IDLE.
REQ-025 An accepted byte SHALL be zero-extended to 8 bits and pushed into the FIFO in the STOP sample cycle.
REQ-026 If the FIFO is full, the byte SHALL be dropped and overflow SHALL set.
REQ-027 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty SHALL derive from the MSB comparison.
REQ-028 Packer: when word_valid = 0, FIFO count >= WORD_BYTES, and delivered < latched word_number, the packer SHALL pop WORD_BYTES bytes in one cycle and assert word_valid on the next cycle.
REQ-029 word_data and word_valid SHALL hold stable until a cycle with word_valid & word_ready; the delivered count SHALL increment in that cycle.
REQ-030 A push and a pop in the same cycle SHALL both take effect; the count SHALL stay consistent.
REQ-031 done SHALL pulse the cycle after the final handshake; busy SHALL clear in that same cycle.
REQ-032 start with word_number = 0 SHALL pulse done on the next cycle, with busy high for one cycle only.
REQ-033 start while busy = 1 SHALL be ignored.
REQ-034 start while idle SHALL clear the FIFO, the delivered count and all sticky flags.
REQ-035 Bytes left in the FIFO at done SHALL be discarded at the next start.
REQ-036 A character in progress when done fires SHALL complete, and its byte SHALL be dropped without error.

Reset
REQ-037 resetn low SHALL immediately force: receiver in IDLE, FIFO empty, pointers 0, delivered count 0, word_data 0, and word_valid, done, busy, frame_err, parity_err, overflow all 0.
REQ-038 Reset asserted mid-character or mid-handshake SHALL abort the transfer; after release, the block SHALL wait for a new start.

Verification
REQ-039 Basic transfer (defaults): start with word_number = 2, then send bytes 11 22 33 44 55 66 77 88 -> word_data 0x44332211, then 0x88776655; done pulses once; no flags set.
REQ-040 Backpressure: hold word_ready low for 50 cycles on the first word -> word_data and word_valid stay stable; no data lost; overflow stays 0.
REQ-041 Framing error: send 0xA5 with a stop bit of 0 -> frame_err = 1, byte discarded; the following 4 good bytes form the word.
REQ-042 Parity (PARITY_EN = 1, PARITY_ODD = 0): 0x03 with parity bit 1 -> parity_err = 1; 0x03 with parity bit 0 -> byte accepted.
REQ-043 Overflow (FIFO_DEPTH = 4, word_ready = 0): send 9 bytes -> 4 bytes packed, 4 buffered, the ninth dropped, overflow = 1.
REQ-044 Glitch and reset: a 3-cycle low pulse on rx -> no byte; then resetn low mid-DATA -> all outputs 0; after release, a new start and a full word receive correctly.
